// File: rtl/book_feed_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// book_pkg - shared widths, side encoding and update payload for the feed merge
// Revision: 1.0
// ============================================================================
package book_pkg;

    localparam int BOOK_PRICE_W = 32;
    localparam int BOOK_SIZE_W  = 32;

    localparam logic SIDE_BID = 1'b0;
    localparam logic SIDE_ASK = 1'b1;

    typedef struct packed {
        logic [BOOK_PRICE_W-1:0] price;
        logic [BOOK_SIZE_W-1:0]  size;
        logic                    side;
    } book_update_t;

endpackage : book_pkg
`default_nettype wire

// File: rtl/book_feed_arbiter_rr.sv
`default_nettype none
// ============================================================================
// rr_arbiter - combinational round-robin pick starting at ptr_i; pointer is external
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    input  logic             enable_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] grant_idx_o,
    output logic             any_o
);

    int               w_pos;
    logic [PTR_W-1:0] w_sel;

    // Scan offsets 0..N-1 from the pointer; the explicit subtract keeps the wrap
    // correct when N is not a power of two.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        w_pos       = 0;
        w_sel       = '0;
        if (enable_i) begin
            for (int k = 0; k < N; k++) begin
                w_pos = int'(ptr_i) + k;
                if (w_pos >= N) begin
                    w_pos = w_pos - N;
                end
                w_sel = PTR_W'(w_pos);
                if (!any_o && req_i[w_sel]) begin
                    any_o          = 1'b1;
                    grant_o[w_sel] = 1'b1;
                    grant_idx_o    = w_sel;
                end
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/book_feed_arbiter.sv
`default_nettype none
// ============================================================================
// book_feed_arbiter - merges feed-handler streams onto the top-of-book update port
// Revision: 1.0
// ============================================================================
module book_feed_arbiter
    import book_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PRICE_W = BOOK_PRICE_W,
    parameter int SIZE_W  = BOOK_SIZE_W,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*PRICE_W-1:0]   req_price,
    input  logic [NUM_REQ*SIZE_W-1:0]    req_size,
    input  logic [NUM_REQ-1:0]           req_side,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         halt,
    output logic                         book_valid,
    output logic [PRICE_W-1:0]           book_price,
    output logic [SIZE_W-1:0]            book_size,
    output logic                         book_side,
    output logic [$clog2(NUM_REQ)-1:0]   book_src,
    output logic [NUM_REQ*CNT_W-1:0]     grant_cnt,
    output logic [NUM_REQ*CNT_W-1:0]     drop_cnt
);

    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] w_grant;
    logic [SRC_W-1:0]   w_idx;
    logic               w_any;
    logic               w_enable;
    logic               w_nonzero;
    logic               w_fwd;
    logic               w_drop;
    book_update_t       w_sel;

    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               book_valid_q, book_valid_d;
    book_update_t       payload_q, payload_d;
    logic [SRC_W-1:0]   src_q, src_d;

    // Grants are withheld during reset as well as on the kill switch.
    assign w_enable = ~halt & rst_n;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (SRC_W)
    ) u_rr (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .enable_i    (w_enable),
        .grant_o     (w_grant),
        .grant_idx_o (w_idx),
        .any_o       (w_any)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_sel       = '0;
        w_sel.price = BOOK_PRICE_W'(req_price[w_idx*PRICE_W +: PRICE_W]);
        w_sel.size  = BOOK_SIZE_W'(req_size[w_idx*SIZE_W +: SIZE_W]);
        w_sel.side  = req_side[w_idx];
    end

    assign w_nonzero = (w_sel.size != '0);
    assign w_fwd     = w_any & w_nonzero;
    assign w_drop    = w_any & ~w_nonzero;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        book_valid_d = w_fwd;
        payload_d    = payload_q;
        src_d        = src_q;
        if (w_any) begin
            rr_ptr_d = (w_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
        if (w_fwd) begin
            payload_d = w_sel;
            src_d     = w_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            book_valid_q   <= 1'b0;
            payload_q      <= '0;
            payload_q.side <= SIDE_BID;
            src_q          <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            book_valid_q <= book_valid_d;
            payload_q    <= payload_d;
            src_q        <= src_d;
        end
    end

    assign book_valid = book_valid_q;
    assign book_price = PRICE_W'(payload_q.price);
    assign book_size  = SIZE_W'(payload_q.size);
    assign book_side  = payload_q.side;
    assign book_src   = src_q;

    // Saturating per-source statistics; they only move on an accepted transfer.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
            logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
            logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

            always_comb begin
                grant_cnt_d = grant_cnt_q;
                drop_cnt_d  = drop_cnt_q;
                if (w_grant[gi] && w_fwd && !(&grant_cnt_q)) begin
                    grant_cnt_d = grant_cnt_q + 1'b1;
                end
                if (w_grant[gi] && w_drop && !(&drop_cnt_q)) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    grant_cnt_q <= '0;
                    drop_cnt_q  <= '0;
                end else begin
                    grant_cnt_q <= grant_cnt_d;
                    drop_cnt_q  <= drop_cnt_d;
                end
            end

            assign grant_cnt[gi*CNT_W +: CNT_W] = grant_cnt_q;
            assign drop_cnt[gi*CNT_W +: CNT_W]  = drop_cnt_q;
        end
    endgenerate

endmodule : book_feed_arbiter
`default_nettype wire

// File: tb/tb_book_feed_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_book_feed_arbiter - directed stimulus, queue-free reference model, per-cycle compare
// Revision: 1.0
// ============================================================================
module tb_book_feed_arbiter;

    localparam int N  = 4;
    localparam int PW = 32;
    localparam int SW = 32;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*PW-1:0]   req_price = '0;
    logic [N*SW-1:0]   req_size = '0;
    logic [N-1:0]      req_side = '0;
    logic [N-1:0]      req_ready;
    logic              halt = 1'b0;
    logic              book_valid;
    logic [PW-1:0]     book_price;
    logic [SW-1:0]     book_size;
    logic              book_side;
    logic [1:0]        book_src;
    logic [N*CW-1:0]   grant_cnt;
    logic [N*CW-1:0]   drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    book_feed_arbiter #(.NUM_REQ(N), .PRICE_W(PW), .SIZE_W(SW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_price  (req_price),
        .req_size   (req_size),
        .req_side   (req_side),
        .req_ready  (req_ready),
        .halt       (halt),
        .book_valid (book_valid),
        .book_price (book_price),
        .book_size  (book_size),
        .book_side  (book_side),
        .book_src   (book_src),
        .grant_cnt  (grant_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_ptr = 0;
    int          m_gcnt [N];
    int          m_dcnt [N];
    logic        m_valid = 1'b0;
    logic [31:0] m_price = '0;
    logic [31:0] m_size = '0;
    logic        m_side = 1'b0;
    int          m_src = 0;
    logic [N-1:0]  p_valid = '0;
    logic [N-1:0]  p_ready = '0;
    logic [N*PW-1:0] p_price = '0;
    logic [N*SW-1:0] p_size = '0;
    logic [N-1:0]  p_side = '0;

    initial begin
        for (int i = 0; i < N; i++) begin
            m_gcnt[i] = 0;
            m_dcnt[i] = 0;
        end
    end

    function automatic int model_winner();
        if (!rst_n || halt) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_price = '0;
            m_size  = '0;
            m_side  = 1'b0;
            m_src   = 0;
            p_valid = '0;
            for (int i = 0; i < N; i++) begin
                m_gcnt[i] = 0;
                m_dcnt[i] = 0;
            end
        end else begin
            w = model_winner();
            // requester rule: a waiting payload must not move
            for (int i = 0; i < N; i++) begin
                if (p_valid[i] && !p_ready[i] && req_valid[i]) begin
                    chk("hold_payload", {req_price[i*PW +: PW], req_size[i*SW +: SW]},
                        {p_price[i*PW +: PW], p_size[i*SW +: SW]});
                end
            end
            p_valid = req_valid;
            p_ready = (w >= 0) ? (N'(1) << w) : '0;
            p_price = req_price;
            p_size  = req_size;
            p_side  = req_side;
            m_valid = 1'b0;
            if (w >= 0) begin
                if (req_size[w*SW +: SW] != 0) begin
                    m_valid = 1'b1;
                    m_price = req_price[w*PW +: PW];
                    m_size  = req_size[w*SW +: SW];
                    m_side  = req_side[w];
                    m_src   = w;
                    if (m_gcnt[w] < 65535) m_gcnt[w] = m_gcnt[w] + 1;
                end else if (m_dcnt[w] < 65535) begin
                    m_dcnt[w] = m_dcnt[w] + 1;
                end
                m_ptr = (w + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        logic [N-1:0]    er;
        logic [N*CW-1:0] eg, ed;
        w  = model_winner();
        er = (w >= 0) ? (N'(1) << w) : '0;
        for (int i = 0; i < N; i++) begin
            eg[i*CW +: CW] = CW'(m_gcnt[i]);
            ed[i*CW +: CW] = CW'(m_dcnt[i]);
        end
        chk("req_ready",  64'(req_ready),  64'(er));
        chk("book_valid", 64'(book_valid), 64'(m_valid));
        chk("book_price", 64'(book_price), 64'(m_price));
        chk("book_size",  64'(book_size),  64'(m_size));
        chk("book_side",  64'(book_side),  64'(m_side));
        chk("book_src",   64'(book_src),   64'(m_src));
        chk("grant_cnt",  64'(grant_cnt),  64'(eg));
        chk("drop_cnt",   64'(drop_cnt),   64'(ed));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [31:0] p, input logic [31:0] s, input logic sd);
        req_price[i*PW +: PW] = p;
        req_size[i*SW +: SW]  = s;
        req_side[i]           = sd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) set_req(i, 32'(100 + i), 32'(10 * (i + 1)), i[0]);
        req_valid = 4'hF;
        tick();
        tick();
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_valid", 64'(book_valid), 64'h0);
        chk("rst_gcnt",  64'(grant_cnt), 64'h0);
        rst_n = 1'b1;
        req_valid = 4'h0;

        // all four continuously valid: strict rotation, one per cycle
        tick();
        req_valid = 4'hF;
        #1 chk("rot_ready0", 64'(req_ready), 64'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rot_valid", 64'(book_valid), 64'h1);
            chk("rot_src",   64'(book_src),   64'(k % 4));
            chk("rot_size",  64'(book_size),  64'(10 * (k % 4 + 1)));
            chk("rot_price", 64'(book_price), 64'(100 + k % 4));
            if (k == 7) req_valid = 4'h0;
            else begin
                #1 chk("rot_ready", 64'(req_ready), 64'(4'b1 << ((k + 1) % 4)));
            end
        end
        tick();
        chk("idle_valid", 64'(book_valid), 64'h0);
        chk("idle_hold",  64'(book_size),  64'd40);
        chk("rot_gcnt",   64'(grant_cnt),  64'h0002_0002_0002_0002);

        // single requester 2
        set_req(2, 32'h64, 32'd5, 1'b0);
        req_valid = 4'b0100;
        #1 chk("r2_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = 4'h0;
        chk("r2_valid", 64'(book_valid), 64'h1);
        chk("r2_price", 64'(book_price), 64'h64);
        chk("r2_size",  64'(book_size),  64'd5);
        chk("r2_side",  64'(book_side),  64'h0);
        chk("r2_src",   64'(book_src),   64'd2);
        chk("r2_gcnt",  64'(grant_cnt[2*CW +: CW]), 64'd3);
        chk("model_g2", 64'(m_gcnt[2]), 64'd3);
        chk("model_ptr3", 64'(m_ptr), 64'd3);

        // zero-size from requester 1: accepted, not forwarded
        set_req(1, 32'h55, 32'd0, 1'b1);
        req_valid = 4'b0010;
        #1 chk("z_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 4'h0;
        chk("z_valid", 64'(book_valid), 64'h0);
        chk("z_hold",  64'(book_price), 64'h64);
        chk("z_dcnt",  64'(drop_cnt[1*CW +: CW]),  64'd1);
        chk("z_gcnt",  64'(grant_cnt[1*CW +: CW]), 64'd2);
        chk("model_d1", 64'(m_dcnt[1]), 64'd1);

        // bring pointer to 3, then raise halt with 0 and 3 waiting
        set_req(2, 32'h70, 32'd7, 1'b1);
        req_valid = 4'b0100;
        tick();
        set_req(0, 32'd200, 32'd11, 1'b0);
        set_req(3, 32'd300, 32'd33, 1'b1);
        halt = 1'b1;
        req_valid = 4'b1001;
        #1;
        chk("h_ready0", 64'(req_ready), 64'h0);
        chk("h_emit",   64'(book_valid), 64'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("h_ready",  64'(req_ready), 64'h0);
            chk("h_valid",  64'(book_valid), 64'h0);
        end
        halt = 1'b0;
        #1 chk("h_rel3", 64'(req_ready), 64'h8);
        tick();
        chk("h_src3", 64'(book_src), 64'd3);
        chk("h_sz3",  64'(book_size), 64'd33);
        #1 chk("h_rel0", 64'(req_ready), 64'h1);
        tick();
        req_valid = 4'h0;
        chk("h_src0", 64'(book_src), 64'd0);
        chk("h_g0",   64'(grant_cnt[0 +: CW]), 64'd3);

        // saturation of grant_cnt[0]
        set_req(0, 32'h500, 32'd1, 1'b0);
        req_valid = 4'b0001;
        repeat (65531) tick();
        chk("sat_fffe", 64'(grant_cnt[0 +: CW]), 64'hFFFE);
        tick();
        chk("sat_ffff", 64'(grant_cnt[0 +: CW]), 64'hFFFF);
        tick();
        tick();
        req_valid = 4'h0;
        chk("sat_stay", 64'(grant_cnt[0 +: CW]), 64'hFFFF);
        chk("model_sat", 64'(m_gcnt[0]), 64'd65535);

        // reset while requester 1's update is pending on the book port
        set_req(1, 32'h99, 32'd9, 1'b1);
        set_req(0, 32'h88, 32'd8, 1'b0);
        req_valid = 4'b0010;
        tick();
        chk("pr_valid", 64'(book_valid), 64'h1);
        chk("pr_src",   64'(book_src),   64'd1);
        req_valid = 4'b0011;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(book_valid), 64'h0);
        chk("ar_ready", 64'(req_ready),  64'h0);
        chk("ar_gcnt",  64'(grant_cnt),  64'h0);
        chk("ar_dcnt",  64'(drop_cnt),   64'h0);
        tick();
        rst_n = 1'b1;
        #1 chk("post_tie", 64'(req_ready), 64'h1);
        tick();
        chk("post_src0", 64'(book_src), 64'd0);
        chk("post_sz",   64'(book_size), 64'd8);
        #1 chk("post_r1", 64'(req_ready), 64'h2);
        tick();
        req_valid = 4'h0;
        chk("post_src1", 64'(book_src), 64'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_book_feed_arbiter
`default_nettype wire
